// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the instruction-fetch front end.
//   - DATA_W        : address / instruction width
//   - RESET_PC      : architectural PC after reset (boot ROM vector)
//   - fetch_state_e : fetch FSM states
//   - fetch_entry_t : {pc, instr} pair handed from fetch to decode
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int                DATA_W   = 32;
    localparam logic [DATA_W-1:0] RESET_PC = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // one cycle after reset release
        ST_ISSUE = 2'd1,   // presenting (or waiting for credit to present) a request
        ST_WAIT  = 2'd2    // one request granted, response not yet returned
    } fetch_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO between fetch and decode, with a single-cycle
//   flush used when the front end is redirected.
// Ports
//   clk        in   1      clock
//   rst        in   1      asynchronous, active-high reset
//   flush      in   1      drop all entries (wins over push/pop)
//   push       in   1      write push_data at the tail
//   push_data  in   WIDTH  entry to write
//   pop        in   1      remove the head entry
//   head_data  out  WIDTH  current head entry (valid when count != 0)
//   count      out  CNT_W  current occupancy
//   count_next out  CNT_W  occupancy after this cycle's push/pop/flush
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is only accepted when the head leaves the same cycle.
    assign pop_ok  = pop  && (count_q != '0);
    assign push_ok = push && ((count_q != DEPTH_C) || pop_ok);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_next = count_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_next = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_next = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_next;
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale data is never used.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//   Holds the architectural PC, issues instruction fetches over a req/gnt +
//   rvalid handshake (one request in flight at most), and queues {pc, instr}
//   pairs for decode. A redirect flushes queued and in-flight wrong-path work.
// Ports
//   clk          in   1       clock
//   rst          in   1       asynchronous, active-high reset
//   pcnext       in   DATA_W  next PC from the next-PC mux
//   redirect     in   1       pcnext is non-sequential: flush and refetch
//   pc           out  DATA_W  current fetch PC (feeds the next-PC mux)
//   imem_req     out  1       fetch request valid
//   imem_addr    out  DATA_W  fetch address (== pc)
//   imem_gnt     in   1       request accepted this cycle
//   imem_rvalid  in   1       response valid (in order, >=1 cycle after gnt)
//   imem_rdata   in   DATA_W  fetched instruction
//   id_valid     out  1       decode FIFO head valid
//   id_instr     out  DATA_W  head instruction
//   id_pc        out  DATA_W  head PC
//   id_ready     in   1       decode consumes the head this cycle
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter int                DATA_W     = mips_pkg::DATA_W,
    parameter logic [DATA_W-1:0] RESET_PC   = mips_pkg::RESET_PC,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pcnext,
    input  logic              redirect,
    output logic [DATA_W-1:0] pc,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instr,
    output logic [DATA_W-1:0] id_pc,
    input  logic              id_ready
);

    import mips_pkg::*;

    localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int               ENTRY_W = 2 * DATA_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    fetch_state_e       state_q, state_d;
    logic [DATA_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  tag_q, tag_d;     // address of the request in flight
    logic               req_q, req_d;
    logic               drop_q, drop_d;   // in-flight response belongs to a flushed path

    logic               gnt_fire;
    logic               rsp;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   fifo_count_next;
    logic [ENTRY_W-1:0] fifo_head;

    // Responses are only meaningful while a request is in flight; anything
    // arriving in IDLE/ISSUE (e.g. a late beat across a reset) is ignored.
    assign gnt_fire = req_q && imem_gnt;
    assign rsp      = (state_q == ST_WAIT) && imem_rvalid;
    assign push     = rsp && !drop_q && !redirect;
    assign pop      = id_valid && id_ready && !redirect;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tag_d   = tag_q;
        drop_d  = drop_q;

        case (state_q)
            ST_IDLE:  state_d = ST_ISSUE;
            ST_ISSUE: if (gnt_fire) state_d = ST_WAIT;
            ST_WAIT:  if (rsp)      state_d = ST_ISSUE;
            default:  state_d = ST_IDLE;
        endcase

        // The address only moves on acceptance or redirect, which keeps
        // imem_addr stable while a request waits for its grant.
        if (redirect || gnt_fire) pc_d  = pcnext;
        if (gnt_fire)             tag_d = pc_q;

        if (redirect) begin
            // Mark the response to discard if one is still to come: either the
            // request just granted, or an older one that is not returning now.
            drop_d = gnt_fire || ((state_q == ST_WAIT) && !rsp);
        end else if (rsp) begin
            drop_d = 1'b0;
        end

        // Issue credit: only ask when the FIFO will have room for the reply.
        // Using next-cycle occupancy lets a pop re-enable the request at once.
        req_d = (state_d == ST_ISSUE) && (fifo_count_next < DEPTH_C);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            tag_q   <= '0;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tag_q   <= tag_d;
            req_q   <= req_d;
            drop_q  <= drop_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .push       (push),
        .push_data  ({tag_q, imem_rdata}),
        .pop        (pop),
        .head_data  (fifo_head),
        .count      (fifo_count),
        .count_next (fifo_count_next)
    );

    assign pc               = pc_q;
    assign imem_req         = req_q;
    assign imem_addr        = pc_q;
    assign id_valid         = (fifo_count != '0);
    assign {id_pc, id_instr} = fifo_head;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pcnext;
    logic        redirect;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt    = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready    = 1'b1;

    int checks = 0;
    int errors = 0;

    // Bench-side controls for the memory responder and next-PC mux.
    logic        gnt_en  = 1'b0;
    logic        rv_hold = 1'b0;
    logic        manual  = 1'b0;
    logic        use_tgt = 1'b0;
    logic [31:0] tgt     = 32'h0;
    logic        pend    = 1'b0;
    logic [31:0] pend_addr = 32'h0;

    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;

    pc_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .pcnext      (pcnext),
        .redirect    (redirect),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_ready    (id_ready)
    );

    always #5 clk = ~clk;

    assign redirect = use_tgt;
    assign pcnext   = use_tgt ? tgt : pc + 32'd4;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    task automatic push_exp(input logic [31:0] a);
        fetch_entry_t e;
        e.pc    = a;
        e.instr = instr_of(a);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
    endtask

    // Memory model: grant when enabled, answer one cycle after the grant.
    always @(negedge clk) begin
        if (!manual) begin
            imem_gnt    = gnt_en && imem_req && !pend;
            imem_rvalid = pend && !rv_hold;
            imem_rdata  = pend ? instr_of(pend_addr) : 32'hDEAD_BEEF;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
        end else if (imem_rvalid && pend) begin
            pend <= 1'b0;
        end else if (imem_req && imem_gnt) begin
            pend      <= 1'b1;
            pend_addr <= imem_addr;
        end
    end

    // Decode-side scoreboard: every accepted head must be the next expected pair.
    always @(negedge clk) begin
        if (!rst && id_valid && id_ready && !redirect) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got pc=%h instr=%h, expected no entry", id_pc, id_instr);
            end else begin
                mon_e = exp_q.pop_front();
                if (id_pc !== mon_e.pc || id_instr !== mon_e.instr) begin
                    errors++;
                    $display("FAIL pop_order: got pc=%h instr=%h, expected pc=%h instr=%h",
                             id_pc, id_instr, mon_e.pc, mon_e.instr);
                end
            end
        end
    end

    task automatic test_reset();
        tick(); tick();
        checks++; if (pc !== 32'hBFC0_0000) begin errors++; $display("FAIL reset_pc: got %h, expected bfc00000", pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, expected 0", imem_req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b, expected 0", id_valid); end
        rst = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b, expected 0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0000) begin
            errors++; $display("FAIL first_req: got req=%b addr=%h, expected req=1 addr=bfc00000", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] addrs [3];
        addrs[0] = 32'hBFC0_0004; addrs[1] = 32'hBFC0_0008; addrs[2] = 32'hBFC0_000C;
        push_exp(32'hBFC0_0000);
        for (int i = 0; i < 3; i++) push_exp(addrs[i]);
        gnt_en = 1'b1;
        tick();   // grant of bfc00000
        checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
            errors++; $display("FAIL seq_wait: got req=%b id_valid=%b, expected 0 0", imem_req, id_valid);
        end
        tick();   // response pushed
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'hBFC0_0000 || id_instr !== instr_of(32'hBFC0_0000)) begin
            errors++; $display("FAIL seq_first_head: got v=%b pc=%h instr=%h, expected v=1 pc=bfc00000 instr=%h",
                               id_valid, id_pc, id_instr, instr_of(32'hBFC0_0000));
        end
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 8 && imem_req !== 1'b1; k++) tick();
            checks++; if (imem_req !== 1'b1 || imem_addr !== addrs[i]) begin
                errors++; $display("FAIL seq_addr%0d: got req=%b addr=%h, expected req=1 addr=%h", i, imem_req, imem_addr, addrs[i]);
            end
            tick();
        end
        gnt_en = 1'b0;
        drain();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL seq_drain: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        id_ready = 1'b0;
        gnt_en   = 1'b1;
        push_exp(32'hBFC0_0010); push_exp(32'hBFC0_0014); push_exp(32'hBFC0_0018);
        for (int i = 0; i < 10; i++) tick();
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'hBFC0_0018) begin
            errors++; $display("FAIL stall_req: got req=%b addr=%h, expected req=0 addr=bfc00018", imem_req, imem_addr);
        end
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'hBFC0_0010) begin
            errors++; $display("FAIL stall_head: got v=%b pc=%h, expected v=1 pc=bfc00010", id_valid, id_pc);
        end
        id_ready = 1'b1;
        tick();
        checks++; if (id_pc !== 32'hBFC0_0014 || imem_req !== 1'b1) begin
            errors++; $display("FAIL stall_resume: got pc=%h req=%b, expected pc=bfc00014 req=1", id_pc, imem_req);
        end
        tick();   // grant of bfc00018
        gnt_en = 1'b0;
        drain();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_redirect_outstanding();
        gnt_en  = 1'b1;
        rv_hold = 1'b1;
        tick();   // grant of bfc0001c, response held back
        gnt_en  = 1'b0;
        use_tgt = 1'b1;
        tgt     = 32'h0040_0100;
        tick();
        use_tgt = 1'b0;
        rv_hold = 1'b0;
        checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0 || pc !== 32'h0040_0100) begin
            errors++; $display("FAIL redir_out_state: got req=%b v=%b pc=%h, expected 0 0 00400100", imem_req, id_valid, pc);
        end
        tick();   // stale response dropped
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin
            errors++; $display("FAIL redir_out_refetch: got v=%b req=%b addr=%h, expected 0 1 00400100", id_valid, imem_req, imem_addr);
        end
        push_exp(32'h0040_0100);
        gnt_en = 1'b1;
        tick();
        gnt_en = 1'b0;
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0040_0100) begin
            errors++; $display("FAIL redir_out_head: got v=%b pc=%h, expected 1 00400100", id_valid, id_pc);
        end
        drain();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL redir_out_drain: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_redirect_rvalid();
        id_ready = 1'b0;
        gnt_en   = 1'b1;
        tick();   // grant of 00400104
        tick();   // pushed, queued (not consumed)
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0040_0104) begin
            errors++; $display("FAIL redir_rv_queued: got v=%b pc=%h, expected 1 00400104", id_valid, id_pc);
        end
        tick();   // grant of 00400108; its response arrives next cycle
        gnt_en  = 1'b0;
        use_tgt = 1'b1;
        tgt     = 32'h0040_0200;
        tick();
        use_tgt = 1'b0;
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0200) begin
            errors++; $display("FAIL redir_rv_flush: got v=%b req=%b addr=%h, expected 0 1 00400200", id_valid, imem_req, imem_addr);
        end
        id_ready = 1'b1;
        tick(); tick(); tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_rv_stale: got v=%b pc=%h, expected v=0", id_valid, id_pc); end
    endtask

    task automatic test_redirect_gnt();
        gnt_en  = 1'b1;
        use_tgt = 1'b1;
        tgt     = 32'h0040_0300;
        tick();   // 00400200 granted in the redirect cycle
        use_tgt = 1'b0;
        gnt_en  = 1'b0;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0040_0300) begin
            errors++; $display("FAIL redir_gnt_state: got req=%b addr=%h, expected 0 00400300", imem_req, imem_addr);
        end
        tick();   // response for 00400200 dropped
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0300) begin
            errors++; $display("FAIL redir_gnt_drop: got v=%b req=%b addr=%h, expected 0 1 00400300", id_valid, imem_req, imem_addr);
        end
        push_exp(32'h0040_0300);
        gnt_en = 1'b1;
        tick();
        gnt_en = 1'b0;
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0040_0300) begin
            errors++; $display("FAIL redir_gnt_head: got v=%b pc=%h, expected 1 00400300", id_valid, id_pc);
        end
        drain();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL redir_gnt_drain: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_gnt_stall();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0304) begin
                errors++; $display("FAIL gnt_stall%0d: got req=%b addr=%h, expected 1 00400304", i, imem_req, imem_addr);
            end
        end
        push_exp(32'h0040_0304);
        gnt_en = 1'b1;
        tick();
        gnt_en = 1'b0;
        drain();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL gnt_stall_drain: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        gnt_en  = 1'b1;
        rv_hold = 1'b1;
        tick();   // 00400308 granted, now in WAIT
        gnt_en      = 1'b0;
        manual      = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        rst         = 1'b1;
        tick(); tick();
        checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0 || pc !== 32'hBFC0_0000) begin
            errors++; $display("FAIL rst_mid_state: got req=%b v=%b pc=%h, expected 0 0 bfc00000", imem_req, id_valid, pc);
        end
        rst = 1'b0;   // rvalid still high: must be ignored
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0000 || id_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_refetch: got req=%b addr=%h v=%b, expected 1 bfc00000 0", imem_req, imem_addr, id_valid);
        end
        imem_rvalid = 1'b0;
        manual      = 1'b0;
        rv_hold     = 1'b0;
        push_exp(32'hBFC0_0000);
        gnt_en = 1'b1;
        tick();
        gnt_en = 1'b0;
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'hBFC0_0000 || id_instr !== instr_of(32'hBFC0_0000)) begin
            errors++; $display("FAIL rst_mid_head: got v=%b pc=%h instr=%h, expected 1 bfc00000 %h",
                               id_valid, id_pc, id_instr, instr_of(32'hBFC0_0000));
        end
        drain();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_mid_drain: got %0d left, expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_outstanding();
        test_redirect_rvalid();
        test_redirect_gnt();
        test_gnt_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
